// File: rtl/uart_frame_packer.sv
// Buffers one payload, then emits 0x55,cmd,N,payload[0..N-1] on a valid/ready byte stream.
// Latency: header is valid one cycle after the closing payload beat; upstream stalls (o_pld_ready=0) while a frame drains, output holds under backpressure.
module uart_frame_packer #(
    parameter int         MAX_LEN = 255,
    parameter logic [7:0] HEADER  = 8'h55
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_pld_data,
    input  logic       i_pld_valid,
    input  logic       i_pld_last,
    output logic       o_pld_ready,
    input  logic [7:0] i_frame_cmd,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_err_trunc
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HDR,
        S_CMD,
        S_LEN,
        S_PLD
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] rcnt_q, rcnt_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] tdata_q, tdata_d;
    logic       tlast_q, tlast_d;
    logic       tvalid_q, tvalid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       trunc_q, trunc_d;

    logic [7:0]    pld_buf_q [MAX_LEN];
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [AW-1:0] buf_raddr;
    logic [7:0]    buf_rdata;

    logic       pld_accept;
    logic       tx_hs;
    logic [7:0] wcnt_inc;
    logic [7:0] rd_next;

    assign o_pld_ready = !i_rst && ((state_q == S_IDLE) || (state_q == S_FILL));
    assign pld_accept  = i_pld_valid && o_pld_ready;
    assign tx_hs       = tvalid_q && i_tready;
    assign wcnt_inc    = wcnt_q + 8'd1;
    assign rd_next     = rcnt_q + 8'd1;

    // rd_next reaches MAX_LEN only on the final beat, where the read data is unused.
    always_comb begin
        buf_raddr = '0;
        if (state_q == S_PLD && rd_next < MAX_LEN_B) begin
            buf_raddr = rd_next[AW-1:0];
        end
    end

    assign buf_rdata = pld_buf_q[buf_raddr];

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        len_d     = len_q;
        cmd_d     = cmd_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        trunc_d   = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = '0;

        case (state_q)
            S_IDLE: begin
                if (pld_accept) begin
                    buf_we = 1'b1;
                    cmd_d  = i_frame_cmd;
                    wcnt_d = 8'd1;
                    busy_d = 1'b1;
                    if (i_pld_last || (MAX_LEN == 1)) begin
                        state_d  = S_HDR;
                        len_d    = 8'd1;
                        tvalid_d = 1'b1;
                        tdata_d  = HEADER;
                        tlast_d  = 1'b0;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (pld_accept) begin
                    buf_we    = 1'b1;
                    buf_waddr = wcnt_q[AW-1:0];
                    wcnt_d    = wcnt_inc;
                    // A full buffer closes the frame even without last; the rest of the
                    // upstream packet becomes the next frame.
                    if (i_pld_last || (wcnt_inc == MAX_LEN_B)) begin
                        state_d  = S_HDR;
                        len_d    = wcnt_inc;
                        tvalid_d = 1'b1;
                        tdata_d  = HEADER;
                        tlast_d  = 1'b0;
                        trunc_d  = !i_pld_last;
                    end
                end
            end
            S_HDR: begin
                if (tx_hs) begin
                    state_d = S_CMD;
                    tdata_d = cmd_q;
                end
            end
            S_CMD: begin
                if (tx_hs) begin
                    state_d = S_LEN;
                    tdata_d = len_q;
                end
            end
            S_LEN: begin
                if (tx_hs) begin
                    state_d = S_PLD;
                    rcnt_d  = 8'd0;
                    tdata_d = pld_buf_q[0];
                    tlast_d = (len_q == 8'd1);
                end
            end
            S_PLD: begin
                if (tx_hs) begin
                    if (tlast_q) begin
                        state_d  = S_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = 8'd0;
                        busy_d   = 1'b0;
                        wcnt_d   = 8'd0;
                        done_d   = 1'b1;
                    end else begin
                        rcnt_d  = rd_next;
                        tdata_d = buf_rdata;
                        tlast_d = (rd_next == (len_q - 8'd1));
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 8'd0;
            rcnt_q   <= 8'd0;
            len_q    <= 8'd0;
            cmd_q    <= 8'd0;
            tdata_q  <= 8'd0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            len_q    <= len_d;
            cmd_q    <= cmd_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            trunc_q  <= trunc_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            pld_buf_q[buf_waddr] <= i_pld_data;
        end
    end

    assign o_tdata      = tdata_q;
    assign o_tlast      = tlast_q;
    assign o_tvalid     = tvalid_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_err_trunc  = trunc_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer: a full-depth instance and a MAX_LEN=4 instance
// share stimulus; sel picks which one the checks observe.
module tb_uart_frame_packer;

    typedef logic [7:0] byte_q_t [$];

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_pld_data;
    logic       i_pld_valid;
    logic       i_pld_last;
    logic [7:0] i_frame_cmd;
    logic       i_tready;

    logic       a_pld_ready, a_tlast, a_tvalid, a_busy, a_frame_done, a_err_trunc;
    logic [7:0] a_tdata;
    logic       b_pld_ready, b_tlast, b_tvalid, b_busy, b_frame_done, b_err_trunc;
    logic [7:0] b_tdata;

    logic       sel;
    logic       m_pld_ready, m_tlast, m_tvalid, m_busy, m_frame_done;
    logic [7:0] m_tdata;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int err_a = 0;
    int err_b = 0;
    int acc_cyc = 0;
    int first_cyc = 0;
    int last_hs_cyc = 0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (a_err_trunc) err_a <= err_a + 1;
        if (b_err_trunc) err_b <= err_b + 1;
    end

    assign m_pld_ready  = sel ? b_pld_ready  : a_pld_ready;
    assign m_tlast      = sel ? b_tlast      : a_tlast;
    assign m_tvalid     = sel ? b_tvalid     : a_tvalid;
    assign m_busy       = sel ? b_busy       : a_busy;
    assign m_frame_done = sel ? b_frame_done : a_frame_done;
    assign m_tdata      = sel ? b_tdata      : a_tdata;

    uart_frame_packer u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pld_data   (i_pld_data),
        .i_pld_valid  (i_pld_valid),
        .i_pld_last   (i_pld_last),
        .o_pld_ready  (a_pld_ready),
        .i_frame_cmd  (i_frame_cmd),
        .o_tdata      (a_tdata),
        .o_tlast      (a_tlast),
        .o_tvalid     (a_tvalid),
        .i_tready     (i_tready),
        .o_busy       (a_busy),
        .o_frame_done (a_frame_done),
        .o_err_trunc  (a_err_trunc)
    );

    uart_frame_packer #(.MAX_LEN(4)) u_dut4 (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pld_data   (i_pld_data),
        .i_pld_valid  (i_pld_valid),
        .i_pld_last   (i_pld_last),
        .o_pld_ready  (b_pld_ready),
        .i_frame_cmd  (i_frame_cmd),
        .o_tdata      (b_tdata),
        .o_tlast      (b_tlast),
        .o_tvalid     (b_tvalid),
        .i_tready     (i_tready),
        .o_busy       (b_busy),
        .o_frame_done (b_frame_done),
        .o_err_trunc  (b_err_trunc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic byte_q_t build_exp(input logic [7:0] cmd, input byte_q_t pld);
        byte_q_t e;
        e.push_back(8'h55);
        e.push_back(cmd);
        e.push_back(8'(pld.size()));
        foreach (pld[i]) e.push_back(pld[i]);
        return e;
    endfunction

    // Bytes before index sw carry cmd_a on i_frame_cmd, the rest cmd_b.
    task automatic send_frame(input byte_q_t pld, input logic [7:0] cmd_a,
                              input logic [7:0] cmd_b, input int sw);
        int w;
        for (int i = 0; i < pld.size(); i++) begin
            i_pld_data  = pld[i];
            i_pld_valid = 1'b1;
            i_pld_last  = (i == pld.size() - 1);
            i_frame_cmd = (i < sw) ? cmd_a : cmd_b;
            w = 0;
            while (!m_pld_ready && w < 3000) begin
                @(negedge i_clk);
                w++;
            end
            if (w >= 3000) check("pld_stall", 32'(m_pld_ready), 32'd1);
            acc_cyc = cyc;
            @(negedge i_clk);
        end
        i_pld_valid = 1'b0;
        i_pld_last  = 1'b0;
    endtask

    task automatic collect(input int bp, output byte_q_t got);
        int         w;
        int         lowrun;
        logic       prev_stall;
        logic [7:0] prev_dat;
        logic       seen;
        logic       fin;
        got = {};
        w = 0;
        lowrun = 0;
        prev_stall = 1'b0;
        prev_dat = 8'd0;
        seen = 1'b0;
        fin = 1'b0;
        while (!fin && w < 3000) begin
            @(negedge i_clk);
            w++;
            if (prev_stall) begin
                check("hold_vld", 32'(m_tvalid), 32'd1);
                check("hold_dat", 32'(m_tdata), 32'(prev_dat));
            end
            if (bp != 0 && lowrun < 5 && $urandom_range(0, 1) == 0) begin
                i_tready = 1'b0;
                lowrun++;
            end else begin
                i_tready = 1'b1;
                lowrun = 0;
            end
            if (m_tvalid) begin
                if (!seen) begin
                    seen = 1'b1;
                    first_cyc = cyc;
                end
                check("rdy_low", 32'(m_pld_ready), 32'd0);
                if (i_tready) begin
                    got.push_back(m_tdata);
                    if (m_tlast) begin
                        fin = 1'b1;
                        last_hs_cyc = cyc;
                    end
                end
            end
            prev_stall = m_tvalid && !i_tready;
            prev_dat = m_tdata;
        end
        check("rx_end", 32'(fin), 32'd1);
        @(negedge i_clk);
        i_tready = 1'b0;
        check("done_pulse", 32'(m_frame_done), 32'd1);
        check("busy_clr", 32'(m_busy), 32'd0);
        check("vld_clr", 32'(m_tvalid), 32'd0);
    endtask

    task automatic cmp_frame(input string tag, input byte_q_t got, input byte_q_t exp);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    byte_q_t p, p1, p2, g1, g2;
    int      e0;
    int      f1_last;

    initial begin
        i_rst = 1'b1;
        sel = 1'b0;
        i_pld_data = 8'd0;
        i_pld_valid = 1'b0;
        i_pld_last = 1'b0;
        i_frame_cmd = 8'd0;
        i_tready = 1'b0;
        repeat (3) @(negedge i_clk);

        check("rst_rdy", 32'(a_pld_ready), 32'd0);
        check("rst_vld", 32'(a_tvalid), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_dat", 32'(a_tdata), 32'd0);
        check("rst_last", 32'(a_tlast), 32'd0);
        check("rst_done", 32'(a_frame_done), 32'd0);
        check("rst_err", 32'(a_err_trunc), 32'd0);
        i_rst = 1'b0;
        #1;
        check("rdy_after_rst", 32'(a_pld_ready), 32'd1);

        // basic three-byte frame
        p = '{8'h11, 8'h22, 8'h33};
        fork
            send_frame(p, 8'hA1, 8'hA1, 99);
            collect(0, g1);
        join
        check("basic_lat", 32'(first_cyc - acc_cyc), 32'd1);
        check("basic_burst", 32'(last_hs_cyc - first_cyc), 32'd5);
        cmp_frame("basic", g1, build_exp(8'hA1, p));

        // single byte
        p = '{8'hFF};
        fork
            send_frame(p, 8'h05, 8'h05, 99);
            collect(0, g1);
        join
        check("single_lat", 32'(first_cyc - acc_cyc), 32'd1);
        check("single_burst", 32'(last_hs_cyc - first_cyc), 32'd3);
        cmp_frame("single", g1, build_exp(8'h05, p));
        check("single_rdy_idle", 32'(a_pld_ready), 32'd1);

        // random backpressure
        p = '{8'h11, 8'h22, 8'h33};
        fork
            send_frame(p, 8'hA1, 8'hA1, 99);
            collect(1, g1);
        join
        cmp_frame("bp", g1, build_exp(8'hA1, p));

        // reset while LEN is presented and stalled
        p = '{8'h77, 8'h88};
        send_frame(p, 8'h3C, 8'h3C, 99);
        check("mid_hdr", 32'(a_tdata), 32'h55);
        i_tready = 1'b1;
        @(negedge i_clk);
        check("mid_cmd", 32'(a_tdata), 32'h3C);
        @(negedge i_clk);
        check("mid_len", 32'(a_tdata), 32'h02);
        i_tready = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("mid_vld", 32'(a_tvalid), 32'd0);
        check("mid_busy", 32'(a_busy), 32'd0);
        check("mid_last", 32'(a_tlast), 32'd0);
        check("mid_rdy", 32'(a_pld_ready), 32'd1);
        p = '{8'h11, 8'h22, 8'h33};
        fork
            send_frame(p, 8'hA1, 8'hA1, 99);
            collect(0, g1);
        join
        check("post_rst_lat", 32'(first_cyc - acc_cyc), 32'd1);
        cmp_frame("post_rst", g1, build_exp(8'hA1, p));

        // two full-depth frames back to back
        p1 = {};
        p2 = {};
        for (int i = 0; i < 255; i++) begin
            p1.push_back(8'(i * 7 + 3));
            p2.push_back(8'(i * 13 + 100));
        end
        fork
            begin
                send_frame(p1, 8'hC1, 8'hC1, 999);
                send_frame(p2, 8'hC2, 8'hC2, 999);
            end
            begin
                collect(0, g1);
                f1_last = last_hs_cyc;
                collect(0, g2);
            end
        join
        cmp_frame("b2b1", g1, build_exp(8'hC1, p1));
        cmp_frame("b2b2", g2, build_exp(8'hC2, p2));
        check("b2b_gap", 32'(first_cyc - f1_last >= 2), 32'd1);
        check("no_trunc_full", 32'(err_a), 32'd0);

        // truncation on the MAX_LEN=4 instance
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        sel = 1'b1;
        #1;
        e0 = err_b;
        p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        fork
            send_frame(p, 8'hC7, 8'hD8, 4);
            begin
                collect(0, g1);
                collect(0, g2);
            end
        join
        p1 = '{8'h01, 8'h02, 8'h03, 8'h04};
        p2 = '{8'h05, 8'h06};
        cmp_frame("trunc1", g1, build_exp(8'hC7, p1));
        cmp_frame("trunc2", g2, build_exp(8'hD8, p2));
        check("trunc_pulses", 32'(err_b - e0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
